// File: rtl/dcache_req_arbiter.sv
// Two-port arbiter onto the single dcache request port, with a LAT-deep tag pipe for response routing
// and a drain/flush handshake. Define DCACHE_ARB_FIXED_PRIO_EN for fixed LSU priority (default: round-robin).
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_ARB   | normal arbitration, one grant per cycle
// ST_DRAIN | flush requested: no grants until the tag pipe is empty
// ST_ACK   | pipe empty: flush_ack pulses for this single cycle
module dcache_req_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [1:0]    req_we,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    input  logic [3:0]    req_wstrb0,
    input  logic [3:0]    req_wstrb1,
    output logic [1:0]    rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          dc_valid,
    input  logic          dc_ready,
    output logic          dc_we,
    output logic [AW-1:0] dc_addr,
    output logic [DW-1:0] dc_wdata,
    output logic [3:0]    dc_wstrb,
    input  logic [DW-1:0] dc_rdata,
    input  logic          flush_req,
    output logic          flush_ack,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t         state;
    logic           gnt;
    logic           accept;
    logic [LAT-1:0] tv;
    logic [LAT-1:0] tid;
    logic [LAT-1:0] twe;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = ~req_valid[0];
    end
`else
    logic rr_ptr;

    always_comb begin
        gnt = req_valid[1];
        if (req_valid == 2'b11) begin
            gnt = rr_ptr;
        end
    end

    // Pointer only moves on acceptance so a stalled grant stays put.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~gnt;
        end
    end
`endif

    // rstn gating keeps the request port quiet while reset is held.
    assign dc_valid  = rstn & (|req_valid) & (state == ST_ARB) & ~flush_req;
    assign accept    = dc_valid & dc_ready;
    assign req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign dc_we     = gnt ? req_we[1]  : req_we[0];
    assign dc_addr   = gnt ? req_addr1  : req_addr0;
    assign dc_wdata  = gnt ? req_wdata1 : req_wdata0;
    assign dc_wstrb  = gnt ? req_wstrb1 : req_wstrb0;

    assign busy      = |tv;
    assign rsp_valid = {tv[LAT-1] & tid[LAT-1], tv[LAT-1] & ~tid[LAT-1]};
    assign rsp_data  = (tv[LAT-1] & ~twe[LAT-1]) ? dc_rdata : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tv  <= '0;
            tid <= '0;
            twe <= '0;
        end else begin
            tv[0]  <= accept;
            tid[0] <= gnt;
            twe[0] <= dc_we;
            for (int i = 1; i < LAT; i++) begin
                tv[i]  <= tv[i-1];
                tid[i] <= tid[i-1];
                twe[i] <= twe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_ARB;
            flush_ack <= 1'b0;
        end else begin
            flush_ack <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (flush_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!busy) begin
                        state     <= ST_ACK;
                        flush_ack <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state <= ST_ARB;
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Directed bench for dcache_req_arbiter: dcache model answers addr+0x8000_0000 after LAT=2 cycles.
// Expectations follow DCACHE_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_dcache_req_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [DW-1:0] req_wdata0, req_wdata1;
    logic [3:0]    req_wstrb0, req_wstrb1;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          dc_valid, dc_ready, dc_we;
    logic [AW-1:0] dc_addr;
    logic [DW-1:0] dc_wdata;
    logic [3:0]    dc_wstrb;
    logic [DW-1:0] dc_rdata;
    logic          flush_req, flush_ack, busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] dp0 = '0;
    logic [DW-1:0] dp1 = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dp0 <= (dc_valid && dc_ready) ? dc_addr + 32'h8000_0000 : 32'h0;
        dp1 <= dp0;
    end
    assign dc_rdata = dp1;

    dcache_req_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_wstrb0(req_wstrb0), .req_wstrb1(req_wstrb1),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_we(dc_we),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb),
        .dc_rdata(dc_rdata),
        .flush_req(flush_req), .flush_ack(flush_ack), .busy(busy)
    );

    task automatic test_reset();
        rstn = 1'b0; req_valid = 2'b11; req_we = 2'b00; dc_ready = 1'b1; flush_req = 1'b0;
        req_addr0 = 32'h10; req_addr1 = 32'h20; req_wdata0 = '0; req_wdata1 = '0;
        req_wstrb0 = 4'hf; req_wstrb1 = 4'hf;
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (dc_valid !== 1'b0) begin errors++; $display("FAIL reset_dc_valid: got %b expected 0", dc_valid); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (flush_ack !== 1'b0) begin errors++; $display("FAIL reset_flush_ack: got %b expected 0", flush_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
`ifdef DCACHE_ARB_FIXED_PRIO_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`endif
        @(negedge clk);
        rstn = 1'b1; req_valid = 2'b11; req_addr0 = 32'h10; req_addr1 = 32'h20;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 4) req_valid = 2'b00;
            #1;
            if (k < 4) begin
                checks++;
                if (req_ready !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_g[k]); end
                checks++;
                if (dc_addr !== ((exp_g[k] == 2'b01) ? 32'h10 : 32'h20)) begin
                    errors++; $display("FAIL rr_dc_addr[%0d]: got %h expected %h", k, dc_addr, (exp_g[k] == 2'b01) ? 32'h10 : 32'h20);
                end
            end
            if (k >= 2) begin
                checks++;
                if (rsp_valid !== exp_g[k-2]) begin errors++; $display("FAIL rr_rsp_valid[%0d]: got %b expected %b", k, rsp_valid, exp_g[k-2]); end
                checks++;
                if (rsp_data !== ((exp_g[k-2] == 2'b01) ? 32'h8000_0010 : 32'h8000_0020)) begin
                    errors++; $display("FAIL rr_rsp_data[%0d]: got %h expected %h", k, rsp_data, (exp_g[k-2] == 2'b01) ? 32'h8000_0010 : 32'h8000_0020);
                end
            end
        end
    endtask

    task automatic test_single_load();
        @(negedge clk);
        req_valid = 2'b01; req_addr0 = 32'h0000_0100; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL load_accept: got %b expected 01", req_ready); end
        checks++; if (dc_addr !== 32'h100) begin errors++; $display("FAIL load_dc_addr: got %h expected 00000100", dc_addr); end
        @(negedge clk);
        req_valid = 2'b00; #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL load_rsp_early: got %b expected 00", rsp_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: got %b expected 1", busy); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL load_rsp_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_data !== 32'h8000_0100) begin errors++; $display("FAIL load_rsp_data: got %h expected 80000100", rsp_data); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_clear: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL load_rsp_once: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_stall_store();
        @(negedge clk);
        req_valid = 2'b10; req_we = 2'b10; req_addr1 = 32'h40; req_wdata1 = 32'hDEAD_BEEF;
        req_wstrb1 = 4'b0011; req_wdata0 = 32'h1111_1111; req_wstrb0 = 4'b1111; dc_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 00", k, req_ready); end
            checks++; if (dc_valid !== 1'b1) begin errors++; $display("FAIL stall_dc_valid[%0d]: got %b expected 1", k, dc_valid); end
            checks++;
            if ({dc_we, dc_addr, dc_wdata, dc_wstrb} !== {1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011}) begin
                errors++; $display("FAIL stall_dc_fields[%0d]: got we=%b addr=%h wdata=%h wstrb=%b expected we=1 addr=00000040 wdata=deadbeef wstrb=0011", k, dc_we, dc_addr, dc_wdata, dc_wstrb);
            end
        end
        @(negedge clk);
        dc_ready = 1'b1; #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_accept: got %b expected 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00; req_we = 2'b00; #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL store_rsp_early: got %b expected 00", rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL store_rsp_valid: got %b expected 10", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL store_rsp_data: got %h expected 00000000", rsp_data); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        req_valid = 2'b01; req_addr0 = 32'h200; req_addr1 = 32'h300; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_pre0: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10; #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL flush_pre1: got %b expected 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b11; flush_req = 1'b1; #1;
        checks++; if (dc_valid !== 1'b0) begin errors++; $display("FAIL flush_dc_valid: got %b expected 0", dc_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_block0: got %b expected 00", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy0: got %b expected 1", busy); end
        checks++; if ({rsp_valid, rsp_data} !== {2'b01, 32'h8000_0200}) begin errors++; $display("FAIL flush_rsp0: got %b/%h expected 01/80000200", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_block1: got %b expected 00", req_ready); end
        checks++; if ({rsp_valid, rsp_data} !== {2'b10, 32'h8000_0300}) begin errors++; $display("FAIL flush_rsp1: got %b/%h expected 10/80000300", rsp_valid, rsp_data); end
        checks++; if ({busy, flush_ack} !== 2'b10) begin errors++; $display("FAIL flush_busy1: got busy=%b ack=%b expected busy=1 ack=0", busy, flush_ack); end
        @(negedge clk); #1;
        checks++; if ({busy, flush_ack} !== 2'b00) begin errors++; $display("FAIL flush_drained: got busy=%b ack=%b expected busy=0 ack=0", busy, flush_ack); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_block2: got %b expected 00", req_ready); end
        @(negedge clk); #1;
        checks++; if (flush_ack !== 1'b1) begin errors++; $display("FAIL flush_ack_pulse: got %b expected 1", flush_ack); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_block_ack: got %b expected 00", req_ready); end
        @(negedge clk);
        flush_req = 1'b0; #1;
        checks++; if (flush_ack !== 1'b0) begin errors++; $display("FAIL flush_ack_width: got %b expected 0", flush_ack); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_resume: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_data} !== {2'b01, 32'h8000_0200}) begin errors++; $display("FAIL flush_resume_rsp: got %b/%h expected 01/80000200", rsp_valid, rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        req_valid = 2'b01; req_addr0 = 32'h500; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_pre_accept: got %b expected 01", req_ready); end
        @(negedge clk);
        rstn = 1'b0; req_valid = 2'b11; flush_req = 1'b1; #1;
        checks++;
        if ({req_ready, dc_valid, rsp_valid, flush_ack, busy} !== 7'b0) begin
            errors++; $display("FAIL rst_outputs: got ready=%b dcv=%b rsp=%b ack=%b busy=%b expected all 0", req_ready, dc_valid, rsp_valid, flush_ack, busy);
        end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_drop_rsp: got %b expected 00", rsp_valid); end
        checks++; if (dc_valid !== 1'b0) begin errors++; $display("FAIL rst_dc_valid: got %b expected 0", dc_valid); end
        @(negedge clk);
        rstn = 1'b1; req_valid = 2'b00; flush_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if ({rsp_valid, busy, flush_ack} !== 4'b0) begin
                errors++; $display("FAIL rst_post[%0d]: got rsp=%b busy=%b ack=%b expected all 0", k, rsp_valid, busy, flush_ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_load();
        test_stall_store();
        test_flush();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
